// File: rtl/seven_segment_cursor_editor_pkg.sv
// Shared definitions for the seven-segment cursor editor: repeat FSM states,
// blink phase encodings and the cursor index stepping helper.
package seven_segment_cursor_editor_pkg;

  typedef logic [1:0] repeat_state_t;

  localparam repeat_state_t RPT_IDLE   = 2'd0;
  localparam repeat_state_t RPT_HOLD   = 2'd1;
  localparam repeat_state_t RPT_REPEAT = 2'd2;

  localparam logic PHASE_VISIBLE = 1'b0;
  localparam logic PHASE_BLANK   = 1'b1;

  // Steps an index up or down within 0..num-1, either wrapping or saturating.
  // Limits are compared explicitly so non-power-of-two digit counts behave.
  function automatic int step_index(input int idx, input int num, input logic up,
                                    input logic wrap);
    int res;
    res = idx;
    if (up) begin
      if (idx >= num - 1) res = wrap ? 0 : num - 1;
      else                res = idx + 1;
    end else begin
      if (idx <= 0) res = wrap ? num - 1 : 0;
      else          res = idx - 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_segment_cursor_editor_if.sv
// Button/display bundle between the debouncers, the editor and the display.
interface seven_segment_cursor_editor_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int CURSOR_W = $clog2(NUM_DIGITS);

  logic                  leftLevel;
  logic                  rightLevel;
  logic                  toggleLevel;
  logic                  clearAll;
  logic                  blinkEnable;
  logic [CURSOR_W-1:0]   cursor;
  logic [NUM_DIGITS-1:0] cursorOneHot;
  logic [NUM_DIGITS-1:0] pointEnable;
  logic [NUM_DIGITS-1:0] digitBlank;

  modport master (
    output leftLevel, rightLevel, toggleLevel, clearAll, blinkEnable,
    input  cursor, cursorOneHot, pointEnable, digitBlank
  );

  modport slave (
    input  leftLevel, rightLevel, toggleLevel, clearAll, blinkEnable,
    output cursor, cursorOneHot, pointEnable, digitBlank
  );
endinterface

// File: rtl/seven_segment_cursor_editor_button_auto_repeat.sv
// Turns a debounced button level into step pulses: one on press, then
// auto-repeat after a hold delay. The step is combinational so the consumer
// registers it on the same edge the press is first sampled.
//
// state      | meaning
// RPT_IDLE   | button released, or held since reset (waiting for a fresh press)
// RPT_HOLD   | pressed, counting the initial hold delay
// RPT_REPEAT | held past the delay, stepping every repeat period
module button_auto_repeat
  import seven_segment_cursor_editor_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic step
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  repeat_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             prev_q;
  logic             rise;

  assign rise = level & ~prev_q;

  // Next state, hold/repeat counter and the step pulse.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    step    = 1'b0;
    if (!level) begin
      state_d = RPT_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (rise) begin
            state_d = RPT_HOLD;
            count_d = '0;
            step    = 1'b1;
          end
        end
        RPT_HOLD: begin
          if (count_q == CNT_W'(REPEAT_DELAY - 1)) begin
            state_d = RPT_REPEAT;
            count_d = '0;
            step    = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (count_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            count_d = '0;
            step    = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State registers; prev level tracks the input during reset so a held button gives no step.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RPT_IDLE;
      count_q <= '0;
      prev_q  <= level;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prev_q  <= level;
    end
  end
endmodule

// File: rtl/seven_segment_cursor_editor.sv
// Cursor / decimal-point editor for an N-digit seven-segment display with
// auto-repeat on left/right, wrap or saturate, clear-all and cursor blink.
module seven_segment_cursor_editor
  import seven_segment_cursor_editor_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int BLINK_HALF    = 12_500_000,
  parameter int WRAP          = 1
) (
  input logic                         clock,
  input logic                         reset,
  seven_segment_cursor_editor_if.slave bus
);
  localparam int CURSOR_W = $clog2(NUM_DIGITS);
  localparam int BLINK_W  = $clog2(BLINK_HALF + 1);

  logic                  left_step, right_step;
  logic                  prev_toggle_q, toggle_rise;
  logic [CURSOR_W-1:0]   cursor_q, cursor_d;
  logic [NUM_DIGITS-1:0] onehot_q, onehot_d;
  logic [NUM_DIGITS-1:0] point_q, point_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;

  button_auto_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_left (
    .clock(clock), .reset(reset), .level(bus.leftLevel), .step(left_step)
  );

  button_auto_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_right (
    .clock(clock), .reset(reset), .level(bus.rightLevel), .step(right_step)
  );

  assign toggle_rise = bus.toggleLevel & ~prev_toggle_q;

  // Cursor move (left wins), point mask edit on the pre-move cursor, blink timing.
  always_comb begin
    cursor_d = cursor_q;
    if (left_step)
      cursor_d = CURSOR_W'(step_index(int'(cursor_q), NUM_DIGITS, 1'b1, WRAP != 0));
    else if (right_step)
      cursor_d = CURSOR_W'(step_index(int'(cursor_q), NUM_DIGITS, 1'b0, WRAP != 0));
    onehot_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << cursor_d;

    point_d = point_q;
    if (bus.clearAll)     point_d = '0;
    else if (toggle_rise) point_d = point_q ^ onehot_q;

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (cursor_d != cursor_q) begin
      blink_cnt_d = '0;
      phase_d     = PHASE_VISIBLE;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end

    blank_d = (bus.blinkEnable && phase_d == PHASE_BLANK) ? onehot_d : '0;
  end

  // Output and timing registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cursor_q      <= '0;
      onehot_q      <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
      point_q       <= '0;
      blank_q       <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= PHASE_VISIBLE;
      prev_toggle_q <= bus.toggleLevel;
    end else begin
      cursor_q      <= cursor_d;
      onehot_q      <= onehot_d;
      point_q       <= point_d;
      blank_q       <= blank_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      prev_toggle_q <= bus.toggleLevel;
    end
  end

  assign bus.cursor       = cursor_q;
  assign bus.cursorOneHot = onehot_q;
  assign bus.pointEnable  = point_q;
  assign bus.digitBlank   = blank_q;
endmodule

// File: tb/tb_seven_segment_cursor_editor.sv
// Scoreboard bench for seven_segment_cursor_editor: dut0 wraps, dut1 saturates.
module tb_seven_segment_cursor_editor;
  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    int         cur;
    logic [5:0] oh;
    logic [5:0] pt;
    logic [5:0] bl;
  } exp_t;

  exp_t q[$];
  exp_t e;

  seven_segment_cursor_editor_if #(.NUM_DIGITS(6)) bus0();
  seven_segment_cursor_editor_if #(.NUM_DIGITS(6)) bus1();

  seven_segment_cursor_editor #(
    .NUM_DIGITS(6), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .BLINK_HALF(8), .WRAP(1)
  ) dut0 (.clock(clock), .reset(reset), .bus(bus0));

  seven_segment_cursor_editor #(
    .NUM_DIGITS(6), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .BLINK_HALF(8), .WRAP(0)
  ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_out(input int dut, input string name, input int cur,
                            input logic [5:0] pt, input logic [5:0] bl);
    exp_t x;
    logic [5:0] one;
    one    = 6'd1;
    x.cyc  = cyc;
    x.dut  = dut;
    x.name = name;
    x.cur  = cur;
    x.oh   = one << cur;
    x.pt   = pt;
    x.bl   = bl;
    q.push_back(x);
  endtask

  task automatic set_left(input int dut, input logic v);
    if (dut == 0) bus0.leftLevel = v; else bus1.leftLevel = v;
  endtask

  task automatic set_right(input int dut, input logic v);
    if (dut == 0) bus0.rightLevel = v; else bus1.rightLevel = v;
  endtask

  task automatic pulse(input int dut, input bit left);
    if (left) set_left(dut, 1'b1); else set_right(dut, 1'b1);
    tick(2);
    if (left) set_left(dut, 1'b0); else set_right(dut, 1'b0);
    tick(2);
  endtask

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      int         a_cur;
      logic [5:0] a_oh, a_pt, a_bl;
      e = q.pop_front();
      if (e.dut == 0) begin
        a_cur = int'(bus0.cursor); a_oh = bus0.cursorOneHot;
        a_pt  = bus0.pointEnable;  a_bl = bus0.digitBlank;
      end else begin
        a_cur = int'(bus1.cursor); a_oh = bus1.cursorOneHot;
        a_pt  = bus1.pointEnable;  a_bl = bus1.digitBlank;
      end
      checks++;
      if (e.cyc != cyc || a_cur != e.cur || a_oh != e.oh || a_pt != e.pt || a_bl != e.bl) begin
        failures++;
        $display("FAIL %s dut%0d: got cursor=%0d onehot=%b point=%b blank=%b, want cursor=%0d onehot=%b point=%b blank=%b (cyc %0d/%0d)",
                 e.name, e.dut, a_cur, a_oh, a_pt, a_bl, e.cur, e.oh, e.pt, e.bl, cyc, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0; checks = 0; failures = 0;
    reset = 1'b1;
    bus0.leftLevel = 0; bus0.rightLevel = 0; bus0.toggleLevel = 0;
    bus0.clearAll = 0;  bus0.blinkEnable = 0;
    bus1.leftLevel = 0; bus1.rightLevel = 0; bus1.toggleLevel = 0;
    bus1.clearAll = 0;  bus1.blinkEnable = 0;
    tick(3);
    expect_out(0, "reset", 0, 6'b0, 6'b0);
    expect_out(1, "reset_w0", 0, 6'b0, 6'b0);
    reset = 1'b0;
    tick(1);

    // Wrapping left steps
    for (int i = 0; i < 7; i++) begin
      pulse(0, 1'b1);
      expect_out(0, "left_wrap", (i + 1) % 6, 6'b0, 6'b0);
    end
    pulse(0, 1'b0);
    expect_out(0, "right_step", 0, 6'b0, 6'b0);

    // Hold-to-repeat: steps on edges 0,20,25,30,35
    bus0.leftLevel = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick(1);
      case (k)
        1:  expect_out(0, "hold_first", 1, 6'b0, 6'b0);
        20: expect_out(0, "hold_delay", 1, 6'b0, 6'b0);
        21: expect_out(0, "hold_rep1", 2, 6'b0, 6'b0);
        25: expect_out(0, "hold_gap", 2, 6'b0, 6'b0);
        26: expect_out(0, "hold_rep2", 3, 6'b0, 6'b0);
        36: expect_out(0, "hold_end", 5, 6'b0, 6'b0);
        default: ;
      endcase
    end
    bus0.leftLevel = 1'b0;
    tick(10);
    expect_out(0, "hold_release", 5, 6'b0, 6'b0);

    // Point toggling and clear priority at cursor 3
    pulse(0, 1'b0);
    pulse(0, 1'b0);
    expect_out(0, "to_cursor3", 3, 6'b0, 6'b0);
    bus0.toggleLevel = 1; tick(1); expect_out(0, "toggle_on", 3, 6'b001000, 6'b0);
    bus0.toggleLevel = 0; tick(1);
    bus0.toggleLevel = 1; tick(1); expect_out(0, "toggle_off", 3, 6'b0, 6'b0);
    bus0.toggleLevel = 0; tick(1);
    bus0.toggleLevel = 1; bus0.clearAll = 1; tick(1);
    bus0.clearAll = 0; expect_out(0, "clear_over_toggle", 3, 6'b0, 6'b0);
    bus0.toggleLevel = 0; tick(1);
    bus0.toggleLevel = 1; tick(1); expect_out(0, "toggle_on2", 3, 6'b001000, 6'b0);
    tick(30); expect_out(0, "toggle_no_repeat", 3, 6'b001000, 6'b0);
    bus0.toggleLevel = 0; tick(1);
    bus0.clearAll = 1; tick(1); bus0.clearAll = 0;
    expect_out(0, "clear_all", 3, 6'b0, 6'b0);

    // Toggle uses pre-move cursor
    bus0.leftLevel = 1; bus0.toggleLevel = 1; tick(1);
    expect_out(0, "toggle_premove", 4, 6'b001000, 6'b0);
    bus0.leftLevel = 0; bus0.toggleLevel = 0; tick(1);
    bus0.clearAll = 1; tick(1); bus0.clearAll = 0;
    expect_out(0, "clear_keep_cursor", 4, 6'b0, 6'b0);

    // Left and right together: left wins
    pulse(0, 1'b0);
    pulse(0, 1'b0);
    expect_out(0, "to_cursor2", 2, 6'b0, 6'b0);
    bus0.leftLevel = 1; bus0.rightLevel = 1; tick(1);
    expect_out(0, "left_wins", 3, 6'b0, 6'b0);
    tick(1);
    bus0.leftLevel = 0; bus0.rightLevel = 0; tick(2);
    expect_out(0, "left_wins_after", 3, 6'b0, 6'b0);

    // Buttons held through reset release
    bus0.leftLevel = 1; bus0.toggleLevel = 1; reset = 1; tick(2);
    expect_out(0, "reset_mid", 0, 6'b0, 6'b0);
    reset = 0; tick(25);
    expect_out(0, "held_thru_reset", 0, 6'b0, 6'b0);
    bus0.leftLevel = 0; bus0.toggleLevel = 0; tick(1);

    // Blink on cursor 4
    bus0.blinkEnable = 1;
    pulse(0, 1'b1); pulse(0, 1'b1); pulse(0, 1'b1);
    bus0.leftLevel = 1; tick(1);
    expect_out(0, "blink_start", 4, 6'b0, 6'b0);
    bus0.leftLevel = 0;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      case (i)
        7:  expect_out(0, "blink_vis_end", 4, 6'b0, 6'b0);
        8:  expect_out(0, "blink_blank", 4, 6'b0, 6'b010000);
        15: expect_out(0, "blink_blank_end", 4, 6'b0, 6'b010000);
        16: expect_out(0, "blink_vis2", 4, 6'b0, 6'b0);
        24: expect_out(0, "blink_blank2", 4, 6'b0, 6'b010000);
        default: ;
      endcase
    end
    bus0.leftLevel = 1; tick(1);
    expect_out(0, "blink_restart", 5, 6'b0, 6'b0);
    bus0.leftLevel = 0; tick(7);
    expect_out(0, "blink_restart_vis", 5, 6'b0, 6'b0);
    tick(1);
    expect_out(0, "blink_restart_blank", 5, 6'b0, 6'b100000);
    bus0.blinkEnable = 0; tick(1);
    expect_out(0, "blink_disabled", 5, 6'b0, 6'b0);

    // Saturating instance
    pulse(1, 1'b0);
    expect_out(1, "sat_low", 0, 6'b0, 6'b0);
    for (int i = 0; i < 6; i++) begin
      pulse(1, 1'b1);
      expect_out(1, "sat_left", (i < 5) ? i + 1 : 5, 6'b0, 6'b0);
    end

    tick(3);
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", q.size());
      failures += q.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
